// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared keccak constants, mode encodings, feeder states and tail-mask helper
package keccak_pkg;

  localparam int KECCAK_W   = 64;
  localparam int MAX_IBYTES = 1568;
  localparam int MAX_OBYTES = 784;

  typedef enum logic [1:0] {
    MODE_SHA3_256 = 2'd0,
    MODE_SHA3_512 = 2'd1,
    MODE_SHAKE128 = 2'd2,
    MODE_SHAKE256 = 2'd3
  } keccak_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_WAIT_DONE
  } feeder_state_t;

  // Keeps the first tb message bytes (MSB-first) of the final word; tb==0 keeps all 8.
  function automatic logic [KECCAK_W-1:0] tail_mask(input logic [2:0] tb);
    logic [KECCAK_W-1:0] ones;
    ones = '1;
    return (tb == 3'd0) ? ones : ~(ones >> {tb, 3'b000});
  endfunction

endpackage

// File: rtl/keccak_word_fifo.sv
// rtl/keccak_word_fifo.sv - small synchronous FIFO holding stream words plus their last flag
module keccak_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keccak_ibytes_feeder.sv
// rtl/keccak_ibytes_feeder.sv - streams a message from word memory to keccak with tail masking
module keccak_ibytes_feeder
  import keccak_pkg::*;
#(
  parameter int DATA_W     = KECCAK_W,
  parameter int MAX_IBYTES = keccak_pkg::MAX_IBYTES,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [10:0]       i_ibytes_len,
  input  logic [9:0]        i_obytes_len,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_mode,
  output logic [10:0]       o_ibytes_len,
  output logic [9:0]        o_obytes_len,
  output logic [DATA_W-1:0] o_ibytes,
  output logic              o_ibytes_valid,
  output logic              o_ibytes_last,
  input  logic              i_ibytes_ready,
  input  logic              i_obytes_done,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  feeder_state_t     state, state_n;
  logic [ADDR_W-1:0] rd_cnt, nwords;
  logic              rd_pending, rd_last;
  logic              start_ok, start_bad, finish;
  logic              pop, fifo_empty;
  logic [DATA_W:0]   fifo_head, push_word;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       occupancy;
  logic [11:0]       len_sum;

  assign len_sum        = {1'b0, i_ibytes_len} + 12'd7;
  assign o_busy         = (state != ST_IDLE);
  assign o_ibytes_valid = (state == ST_FEED) && !fifo_empty;
  assign pop            = o_ibytes_valid && i_ibytes_ready;
  assign o_ibytes       = o_ibytes_valid ? fifo_head[DATA_W-1:0] : '0;
  assign o_ibytes_last  = o_ibytes_valid && fifo_head[DATA_W];

  // The slot being popped this cycle is already free for a new read.
  assign occupancy  = (CW+1)'(fifo_cnt) - (CW+1)'(pop) + (CW+1)'(rd_pending);
  assign o_mem_rd   = (state == ST_FEED) && (rd_cnt < nwords) && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign o_mem_addr = rd_cnt;
  assign push_word  = {rd_last, i_mem_rdata & (rd_last ? tail_mask(o_ibytes_len[2:0]) : '1)};

  keccak_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (i_clk),
    .rstn      (i_rstn),
    .push      (rd_pending),
    .push_data (push_word),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_n   = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_ibytes_len > 11'(MAX_IBYTES)) begin
            start_bad = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_n  = (i_ibytes_len == 11'd0) ? ST_WAIT_DONE : ST_FEED;
          end
        end
      end
      ST_FEED: begin
        if (pop && fifo_head[DATA_W]) state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_obytes_done) begin
          state_n = ST_IDLE;
          finish  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= ST_IDLE;
      rd_cnt       <= '0;
      nwords       <= '0;
      rd_pending   <= 1'b0;
      rd_last      <= 1'b0;
      o_mode       <= '0;
      o_ibytes_len <= '0;
      o_obytes_len <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state      <= state_n;
      o_done     <= finish;
      o_err      <= start_bad;
      rd_pending <= o_mem_rd;
      rd_last    <= o_mem_rd && (rd_cnt == nwords - 1'b1);
      if (start_ok) begin
        o_mode       <= i_mode;
        o_ibytes_len <= i_ibytes_len;
        o_obytes_len <= i_obytes_len;
        nwords       <= ADDR_W'(len_sum[11:3]);
        rd_cnt       <= '0;
      end else if (o_mem_rd) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keccak_ibytes_feeder.sv
// tb/tb_keccak_ibytes_feeder.sv - randomized self-checking bench for keccak_ibytes_feeder
module tb_keccak_ibytes_feeder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  mode;
  logic [10:0] ibytes_len;
  logic [9:0]  obytes_len;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [63:0] mem_rdata;
  logic [1:0]  k_mode;
  logic [10:0] k_ibytes_len;
  logic [9:0]  k_obytes_len;
  logic [63:0] ibytes;
  logic        ibytes_valid, ibytes_last, ibytes_ready, obytes_done;
  logic        busy, done, err;

  always #5 clk = ~clk;

  keccak_ibytes_feeder dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_start        (start),
    .i_mode         (mode),
    .i_ibytes_len   (ibytes_len),
    .i_obytes_len   (obytes_len),
    .o_mem_rd       (mem_rd),
    .o_mem_addr     (mem_addr),
    .i_mem_rdata    (mem_rdata),
    .o_mode         (k_mode),
    .o_ibytes_len   (k_ibytes_len),
    .o_obytes_len   (k_obytes_len),
    .o_ibytes       (ibytes),
    .o_ibytes_valid (ibytes_valid),
    .o_ibytes_last  (ibytes_last),
    .i_ibytes_ready (ibytes_ready),
    .i_obytes_done  (obytes_done),
    .o_busy         (busy),
    .o_done         (done),
    .o_err          (err)
  );

  logic [63:0] mem [0:255];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          job_len, job_nw, popped, reads, ready_mode;
  logic [1:0]  job_mode;
  logic [9:0]  job_olen;
  bit          prev_stall;
  logic [64:0] prev_word;

  // Byte 8k+j of the message sits in bits [63-8j -: 8] of word k; bytes past len read as zero.
  function automatic logic [63:0] exp_word(input int k, input int len);
    logic [63:0] w;
    w = mem[k];
    for (int j = 0; j < 8; j++)
      if (8 * k + j >= len) w[63 - 8 * j -: 8] = 8'h00;
    return w;
  endfunction

  task automatic observe();
    if (prev_stall) begin
      check("stall_valid", ibytes_valid, 1);
      check("stall_data", ibytes, prev_word[63:0]);
      check("stall_last", ibytes_last, prev_word[64]);
    end
    prev_stall = ibytes_valid && !ibytes_ready;
    prev_word  = {ibytes_last, ibytes};
    if (mem_rd) begin
      check("rd_addr", mem_addr, reads);
      reads++;
      check("rd_within_msg", reads <= job_nw, 1);
    end
    if (ibytes_valid && ibytes_ready) begin
      check("extra_word", popped < job_nw, 1);
      if (popped < job_nw) begin
        check("data", ibytes, exp_word(popped, job_len));
        check("last", ibytes_last, popped == job_nw - 1);
      end
      check("held_ibytes_len", k_ibytes_len, job_len);
      check("held_mode", k_mode, job_mode);
      check("held_obytes_len", k_obytes_len, job_olen);
      popped++;
    end
    check("readahead", (reads - popped) <= 2, 1);
  endtask

  task automatic cycle(input bit st);
    @(negedge clk);
    start = st;
    if (st) begin
      ibytes_len = 11'd16;
      mode       = ~job_mode;
    end
    case (ready_mode)
      0:       ibytes_ready = 1'b1;
      1:       ibytes_ready = ~ibytes_ready;
      default: ibytes_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    observe();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, ibytes_valid, 0);
    check({tag, "_last"}, ibytes_last, 0);
    check({tag, "_ibytes"}, ibytes, 0);
    check({tag, "_rd"}, mem_rd, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_mode"}, k_mode, 0);
    check({tag, "_ilen"}, k_ibytes_len, 0);
    check({tag, "_olen"}, k_obytes_len, 0);
  endtask

  task automatic run_job(input int len, input int rmode, input int abort_at, input bit glitch);
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    job_len    = len;
    job_nw     = (len + 7) / 8;
    job_mode   = 2'($urandom_range(0, 3));
    job_olen   = 10'($urandom_range(1, 784));
    ready_mode = rmode;
    popped     = 0;
    reads      = 0;
    prev_stall = 0;
    @(negedge clk);
    start      = 1'b1;
    mode       = job_mode;
    ibytes_len = 11'(len);
    obytes_len = job_olen;
    cycle(0);
    check("busy_t1", busy, 1);
    check("rd_t1", mem_rd, len > 0);
    check("valid_t1", ibytes_valid, 0);
    cycle(0);
    check("valid_t2", ibytes_valid, 0);
    cycle(0);
    check("valid_t3", ibytes_valid, len > 0);
    guard = 0;
    while (popped < job_nw && guard < 2000) begin
      if (abort_at >= 0 && popped >= abort_at) break;
      cycle(glitch && guard == 4);
      guard++;
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      #1;
      check_all_zero("after_reset");
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        #1;
        check("no_done_after_abort", done, 0);
        check("idle_after_abort", busy, 0);
      end
      return;
    end
    check("words_delivered", popped, job_nw);
    for (int i = 0; i < 3; i++) begin
      cycle(0);
      check("wait_busy", busy, 1);
      check("wait_no_done", done, 0);
      check("wait_ibytes_len", k_ibytes_len, job_len);
    end
    @(negedge clk);
    obytes_done = 1'b1;
    @(negedge clk);
    obytes_done = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic reject_test(input int len);
    job_nw = 0;
    reads  = 0;
    @(negedge clk);
    start      = 1'b1;
    ibytes_len = 11'(len);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_rd", mem_rd, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("err_cleared", err, 0);
      check("err_stays_idle", busy, 0);
      check("err_no_rd", mem_rd, 0);
    end
  endtask

  initial begin
    rstn         = 1'b0;
    start        = 1'b0;
    mode         = '0;
    ibytes_len   = '0;
    obytes_len   = '0;
    ibytes_ready = 1'b0;
    obytes_done  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    run_job(16, 0, -1, 0);
    run_job(13, 0, -1, 0);
    run_job(40, 1, -1, 1);
    run_job(0, 0, -1, 0);
    reject_test(1569);
    reject_test(2047);
    run_job(168, 0, 3, 0);
    run_job(168, 0, -1, 0);
    run_job(1, 2, -1, 0);
    run_job(8, 0, -1, 0);
    run_job(1568, 2, -1, 0);
    for (int i = 0; i < 6; i++) run_job($urandom_range(0, 1568), 2, -1, i[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
